// File: rtl/llm_pkg.sv
// Shared color codes, FSM encoding and color decode for the phase sequencer.
package llm_pkg;

   localparam logic [1:0] COL_OFF    = 2'b00;
   localparam logic [1:0] COL_GREEN  = 2'b01;
   localparam logic [1:0] COL_YELLOW = 2'b10;
   localparam logic [1:0] COL_RED    = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_e;

   // Decode a color code to {red, yellow, green}; COL_OFF gives all zero.
   function automatic logic [2:0] color_onehot(input logic [1:0] col);
      logic [2:0] oh;
      oh = 3'b000;
      case (col)
         COL_GREEN:  oh = 3'b001;
         COL_YELLOW: oh = 3'b010;
         COL_RED:    oh = 3'b100;
         default:    oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/llm_sched_table.sv
// Schedule register file: synchronous gated write, asynchronous full read-out.
module llm_sched_table #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDX_W = 3,
   parameter int unsigned DUR_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             we_i,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] addr_i,
   input  logic [1:0]       color_i,
   input  logic [DUR_W-1:0] dur_i,
   output logic [1:0]       color_o [DEPTH],
   output logic [DUR_W-1:0] dur_o   [DEPTH]
);

   logic [1:0]       color_q [DEPTH];
   logic [DUR_W-1:0] dur_q   [DEPTH];

   // Entry storage; writes are dropped while the gate is low (run in progress).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            color_q[i] <= '0;
            dur_q[i]   <= '0;
         end
      end else if (we_i && wr_en_i) begin
         color_q[addr_i] <= color_i;
         dur_q[addr_i]   <= dur_i;
      end
   end

   assign color_o = color_q;
   assign dur_o   = dur_q;

endmodule

// File: rtl/llm_phase_sequencer.sv
// Table-driven green/yellow/red phase sequencer with deception edge monitoring.
module llm_phase_sequencer
   import llm_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDX_W = 3,
   parameter int unsigned DUR_W = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_addr,
   input  logic [1:0]       cfg_color,
   input  logic [DUR_W-1:0] cfg_dur,
   input  logic             start,
   input  logic             stop,
   input  logic             loop_en,
   input  logic             deception_in,
   output logic             green,
   output logic             yellow,
   output logic             red,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] phase_idx,
   output logic [DUR_W-1:0] phase_left,
   output logic [CNT_W-1:0] dec_cnt,
   output logic [IDX_W-1:0] dec_first_idx,
   output logic             dec_seen
);

   logic [1:0]       tbl_color [DEPTH];
   logic [DUR_W-1:0] tbl_dur   [DEPTH];

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
   logic [DUR_W-1:0] left_q, left_d;
   logic [2:0]       col_q, col_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             clr_cnt, sched_end;

   logic             dec_in_q, dec_edge;
   logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
   logic [IDX_W-1:0] dec_first_q, dec_first_d;
   logic             dec_seen_q, dec_seen_d;

   llm_sched_table #(
      .DEPTH(DEPTH),
      .IDX_W(IDX_W),
      .DUR_W(DUR_W)
   ) u_table (
      .clock   (clock),
      .reset_n (reset_n),
      .we_i    (cfg_we),
      .wr_en_i (~busy_q),
      .addr_i  (cfg_addr),
      .color_i (cfg_color),
      .dur_i   (cfg_dur),
      .color_o (tbl_color),
      .dur_o   (tbl_dur)
   );

   // Sequencer next state: start/stop handling, per-entry countdown and advance/wrap.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      left_d    = left_q;
      done_d    = 1'b0;
      clr_cnt   = 1'b0;
      nxt_idx   = idx_q + IDX_W'(1);
      sched_end = (idx_q == IDX_W'(DEPTH - 1)) || (tbl_dur[nxt_idx] == '0);
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               clr_cnt = 1'b1;
               if (tbl_dur[0] != '0) begin
                  state_d = RUN;
                  idx_d   = '0;
                  left_d  = tbl_dur[0];
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (left_q == DUR_W'(1)) begin
               if (sched_end) begin
                  if (loop_en) begin
                     idx_d  = '0;
                     left_d = tbl_dur[0];
                  end else begin
                     state_d = FIN;
                  end
               end else begin
                  idx_d  = nxt_idx;
                  left_d = tbl_dur[nxt_idx];
               end
            end else begin
               left_d = left_q - DUR_W'(1);
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == FIN) done_d = 1'b1;
      busy_d = (state_d == RUN);
      col_d  = (state_d == RUN) ? color_onehot(tbl_color[idx_d]) : 3'b000;
   end

   // Deception edge counting: cleared on run accept, counted only while running.
   always_comb begin
      dec_cnt_d   = dec_cnt_q;
      dec_first_d = dec_first_q;
      dec_seen_d  = dec_seen_q;
      dec_edge    = deception_in & ~dec_in_q;
      if (clr_cnt) begin
         dec_cnt_d   = '0;
         dec_first_d = '0;
         dec_seen_d  = 1'b0;
      end else if ((state_q == RUN) && dec_edge) begin
         if (dec_cnt_q != '1) dec_cnt_d = dec_cnt_q + CNT_W'(1);
         if (!dec_seen_q) begin
            dec_seen_d  = 1'b1;
            dec_first_d = idx_q;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         left_q      <= '0;
         col_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dec_in_q    <= 1'b0;
         dec_cnt_q   <= '0;
         dec_first_q <= '0;
         dec_seen_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         left_q      <= left_d;
         col_q       <= col_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dec_in_q    <= deception_in;
         dec_cnt_q   <= dec_cnt_d;
         dec_first_q <= dec_first_d;
         dec_seen_q  <= dec_seen_d;
      end
   end

   assign green         = col_q[0];
   assign yellow        = col_q[1];
   assign red           = col_q[2];
   assign busy          = busy_q;
   assign done          = done_q;
   assign phase_idx     = idx_q;
   assign phase_left    = left_q;
   assign dec_cnt       = dec_cnt_q;
   assign dec_first_idx = dec_first_q;
   assign dec_seen      = dec_seen_q;

endmodule

// File: tb/tb_llm_phase_sequencer.sv
// Directed bench for llm_phase_sequencer: vector table plus multi-cycle scenarios.
module tb_llm_phase_sequencer;

   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] O = 3'b000;

   logic       clock, reset_n;
   logic       cfg_we;
   logic [2:0] cfg_addr;
   logic [1:0] cfg_color;
   logic [7:0] cfg_dur;
   logic       start, stop, loop_en, deception_in;
   logic       green, yellow, red, busy, done, dec_seen;
   logic [2:0] phase_idx, dec_first_idx;
   logic [7:0] phase_left, dec_cnt;

   int passed = 0;
   int total  = 0;
   int done_seen;

   typedef struct packed {
      logic       start;
      logic       stop;
      logic       dec;
      logic       busy;
      logic [2:0] col;
      logic [2:0] idx;
      logic [7:0] left;
      logic       done;
      logic [7:0] cnt;
      logic       seen;
      logic [2:0] first;
   } vec_t;

   vec_t vecs [10];

   llm_phase_sequencer dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .cfg_we        (cfg_we),
      .cfg_addr      (cfg_addr),
      .cfg_color     (cfg_color),
      .cfg_dur       (cfg_dur),
      .start         (start),
      .stop          (stop),
      .loop_en       (loop_en),
      .deception_in  (deception_in),
      .green         (green),
      .yellow        (yellow),
      .red           (red),
      .busy          (busy),
      .done          (done),
      .phase_idx     (phase_idx),
      .phase_left    (phase_left),
      .dec_cnt       (dec_cnt),
      .dec_first_idx (dec_first_idx),
      .dec_seen      (dec_seen)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         passed++;
   endtask

   task automatic write_entry(input logic [2:0] a, input logic [1:0] c, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_color = c; cfg_dur = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   function automatic logic [2:0] cols();
      return {red, yellow, green};
   endfunction

   // Expected color k cycles into the 40/12/120 schedule (k starts at 1).
   function automatic logic [2:0] main_col(input int k);
      if (k <= 40) return G;
      if (k <= 52) return R;
      if (k <= 172) return G;
      return O;
   endfunction

   initial begin
      reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_color = '0; cfg_dur = '0;
      start = 1'b0; stop = 1'b0; loop_en = 1'b0; deception_in = 1'b0;
      #3;
      check("rst_cols", 32'(cols()), 32'(O));
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_idx", 32'(phase_idx), 0);
      check("rst_left", 32'(phase_left), 0);
      check("rst_cnt", 32'(dec_cnt), 0);
      step(); step();
      reset_n = 1'b1;
      step();

      // Short schedule: green/2, yellow/1, red/2, end.
      write_entry(3'd0, 2'b01, 8'd2);
      write_entry(3'd1, 2'b10, 8'd1);
      write_entry(3'd2, 2'b11, 8'd2);

      //              st  sp  dec busy col idx left   done cnt   seen first
      vecs[0] = '{1'b1,1'b0,1'b0,1'b1, G, 3'd0,8'd2,1'b0,8'd0,1'b0,3'd0};
      vecs[1] = '{1'b0,1'b0,1'b0,1'b1, G, 3'd0,8'd1,1'b0,8'd0,1'b0,3'd0};
      vecs[2] = '{1'b0,1'b0,1'b0,1'b1, Y, 3'd1,8'd1,1'b0,8'd0,1'b0,3'd0};
      vecs[3] = '{1'b0,1'b0,1'b1,1'b1, R, 3'd2,8'd2,1'b0,8'd1,1'b1,3'd1};
      vecs[4] = '{1'b0,1'b0,1'b0,1'b1, R, 3'd2,8'd1,1'b0,8'd1,1'b1,3'd1};
      vecs[5] = '{1'b0,1'b0,1'b1,1'b0, O, 3'd2,8'd1,1'b1,8'd2,1'b1,3'd1};
      vecs[6] = '{1'b0,1'b0,1'b1,1'b0, O, 3'd2,8'd1,1'b0,8'd2,1'b1,3'd1};
      vecs[7] = '{1'b1,1'b1,1'b1,1'b0, O, 3'd2,8'd1,1'b0,8'd2,1'b1,3'd1};
      vecs[8] = '{1'b1,1'b0,1'b1,1'b1, G, 3'd0,8'd2,1'b0,8'd0,1'b0,3'd0};
      vecs[9] = '{1'b0,1'b1,1'b1,1'b0, O, 3'd0,8'd2,1'b0,8'd0,1'b0,3'd0};

      for (int i = 0; i < 10; i++) begin
         start = vecs[i].start; stop = vecs[i].stop; deception_in = vecs[i].dec;
         step();
         check($sformatf("v%0d_cols", i), 32'(cols()), 32'(vecs[i].col));
         check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
         check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
         check($sformatf("v%0d_idx", i), 32'(phase_idx), 32'(vecs[i].idx));
         check($sformatf("v%0d_left", i), 32'(phase_left), 32'(vecs[i].left));
         check($sformatf("v%0d_cnt", i), 32'(dec_cnt), 32'(vecs[i].cnt));
         check($sformatf("v%0d_seen", i), 32'(dec_seen), 32'(vecs[i].seen));
         check($sformatf("v%0d_first", i), 32'(dec_first_idx), 32'(vecs[i].first));
      end
      start = 1'b0; stop = 1'b0; deception_in = 1'b0;
      step();

      // Main schedule: green/40, red/12, green/120, end.
      write_entry(3'd0, 2'b01, 8'd40);
      write_entry(3'd1, 2'b11, 8'd12);
      write_entry(3'd2, 2'b01, 8'd120);
      write_entry(3'd3, 2'b00, 8'd0);

      // Single pass.
      pulse_start();
      done_seen = 0;
      for (int k = 1; k <= 175; k++) begin
         check($sformatf("once_cols_k%0d", k), 32'(cols()), 32'(main_col(k)));
         check($sformatf("once_busy_k%0d", k), 32'(busy), 32'(k <= 172));
         check($sformatf("once_done_k%0d", k), 32'(done), 32'(k == 173));
         if (done) done_seen++;
         step();
      end
      check("once_done_count", 32'(done_seen), 1);

      // Looping run: entries cycle 0,1,2,0,... with no gap at the wrap.
      loop_en = 1'b1;
      pulse_start();
      for (int k = 1; k <= 400; k++) begin
         int p;
         p = (k - 1) % 172;
         check($sformatf("loop_busy_k%0d", k), 32'(busy), 1);
         check($sformatf("loop_idx_k%0d", k), 32'(phase_idx),
               (p < 40) ? 0 : (p < 52) ? 1 : 2);
         check($sformatf("loop_cols_k%0d", k), 32'(cols()), 32'(main_col(p + 1)));
         step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0; loop_en = 1'b0;
      check("loop_stop_busy", 32'(busy), 0);
      check("loop_stop_done", 32'(done), 0);
      check("loop_stop_cols", 32'(cols()), 32'(O));
      step();

      // Deception edges: two in entry 1, one in entry 2.
      pulse_start();
      for (int k = 1; k <= 175; k++) begin
         deception_in = (k == 42 || k == 45 || k == 60);
         step();
      end
      deception_in = 1'b0;
      check("dec_cnt", 32'(dec_cnt), 3);
      check("dec_seen", 32'(dec_seen), 1);
      check("dec_first", 32'(dec_first_idx), 1);

      // New start clears counters; then mid-run write, deception in entry 0, stop in entry 1.
      pulse_start();
      check("clr_cnt", 32'(dec_cnt), 0);
      check("clr_seen", 32'(dec_seen), 0);
      check("clr_first", 32'(dec_first_idx), 0);
      check("clr_busy", 32'(busy), 1);
      for (int k = 1; k <= 45; k++) begin
         deception_in = (k == 5);
         cfg_we = (k == 20); cfg_addr = 3'd1; cfg_color = 2'b10; cfg_dur = 8'd3;
         stop = (k == 45);
         step();
      end
      cfg_we = 1'b0; stop = 1'b0; deception_in = 1'b0;
      check("stop_cols", 32'(cols()), 32'(O));
      check("stop_busy", 32'(busy), 0);
      check("stop_done", 32'(done), 0);
      check("stop_cnt", 32'(dec_cnt), 1);
      check("stop_seen", 32'(dec_seen), 1);
      check("stop_first", 32'(dec_first_idx), 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("stop_nodone_%0d", k), 32'(done), 0);
      end

      // Rerun: entry 1 still red/12 despite the mid-run write.
      pulse_start();
      for (int k = 1; k <= 53; k++) begin
         if (k == 41 || k == 52 || k == 53)
            check($sformatf("frozen_cols_k%0d", k), 32'(cols()), 32'(main_col(k)));
         step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      step();

      // One-cycle yellow entry.
      write_entry(3'd0, 2'b10, 8'd1);
      write_entry(3'd1, 2'b00, 8'd0);
      pulse_start();
      check("single_cols", 32'(cols()), 32'(Y));
      check("single_busy", 32'(busy), 1);
      check("single_left", 32'(phase_left), 1);
      step();
      check("single_done", 32'(done), 1);
      check("single_cols_fin", 32'(cols()), 32'(O));
      check("single_busy_fin", 32'(busy), 0);
      step();
      check("single_done_clr", 32'(done), 0);

      // Empty schedule: immediate done, never busy.
      write_entry(3'd0, 2'b01, 8'd0);
      pulse_start();
      check("empty_done", 32'(done), 1);
      check("empty_busy", 32'(busy), 0);
      step();
      check("empty_done_clr", 32'(done), 0);
      check("empty_busy2", 32'(busy), 0);

      // Asynchronous reset mid-run.
      write_entry(3'd0, 2'b11, 8'd10);
      pulse_start();
      step(); step();
      check("pre_rst_cols", 32'(cols()), 32'(R));
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_cols", 32'(cols()), 32'(O));
      check("arst_busy", 32'(busy), 0);
      check("arst_idx", 32'(phase_idx), 0);
      check("arst_left", 32'(phase_left), 0);
      #1;
      reset_n = 1'b1;
      step();
      pulse_start();
      check("post_rst_done", 32'(done), 1);
      check("post_rst_busy", 32'(busy), 0);
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
